// File: rtl/src_datapath_pkg.sv
// Shared encodings for the SRC datapath: ALU operation codes, bus source codes
// and default widths.
package src_datapath_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_GP = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_ZERO = 4'd15;

  // Codes below DEF_NUM_GP select the general-purpose registers directly.
  localparam logic [4:0] BUS_HI  = 5'd16;
  localparam logic [4:0] BUS_LO  = 5'd17;
  localparam logic [4:0] BUS_ZHI = 5'd18;
  localparam logic [4:0] BUS_ZLO = 5'd19;
  localparam logic [4:0] BUS_PC  = 5'd20;
  localparam logic [4:0] BUS_MDR = 5'd21;

endpackage

// File: rtl/src_datapath_alu.sv
// Combinational ALU for the SRC datapath producing a 64-bit result for Z.
// MUL and DIV exist only when SRC_MULDIV_EN is defined; otherwise they yield 0.
module src_alu
  import src_datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [3:0]          op,
  output logic [2*DATA_W-1:0] result
);

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0]      sh;
  logic [2*DATA_W-1:0] dbl;
  logic [2*DATA_W-1:0] ror_full;
  logic [2*DATA_W-1:0] rol_full;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   hi;

  // Rotations shift a doubled copy so the wrapped bits fall into the kept half.
  assign sh       = b[SHW-1:0];
  assign dbl      = {a, a};
  assign ror_full = dbl >> sh;
  assign rol_full = dbl << sh;

`ifdef SRC_MULDIV_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
`endif

  always_comb begin
    lo = '0;
    hi = '0;
    case (op)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_SHR:  lo = a >> sh;
      OP_SHRA: lo = DATA_W'($signed(a) >>> sh);
      OP_SHL:  lo = a << sh;
      OP_ROR:  lo = ror_full[DATA_W-1:0];
      OP_ROL:  lo = rol_full[2*DATA_W-1:DATA_W];
`ifdef SRC_MULDIV_EN
      OP_MUL: begin
        lo = prod[DATA_W-1:0];
        hi = prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
        end else begin
          lo = DATA_W'($signed(a) / $signed(b));
          hi = DATA_W'($signed(a) % $signed(b));
        end
      end
`endif
      OP_NEG:  lo = '0 - b;
      OP_NOT:  lo = ~b;
      OP_PASS: lo = b;
      OP_INC:  lo = b + 1'b1;
      default: lo = '0;
    endcase
  end

  assign result = {hi, lo};

endmodule

// File: rtl/src_datapath.sv
// SRC single-bus datapath: register file, special registers, bus mux and ALU.
// Define SRC_MULDIV_EN to include the signed multiplier and divider in the ALU.
module src_datapath
  import src_datapath_pkg::*;
#(
  parameter int NUM_GP = DEF_NUM_GP,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      incPC,
  input  logic [$clog2(NUM_GP)-1:0] GP_addr,
  input  logic [DATA_W-1:0]         Mdatain,
  input  logic                      MDR_read,
  input  logic                      e_PC,
  input  logic                      e_IR,
  input  logic                      e_Y,
  input  logic                      e_Z,
  input  logic                      e_HI,
  input  logic                      e_LO,
  input  logic                      e_MDR,
  input  logic                      e_MAR,
  input  logic                      e_GP,
  input  logic [3:0]                ALU_op,
  input  logic [4:0]                BusDataSelect,
  output logic [DATA_W-1:0]         bus_out,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         ir_out,
  output logic [DATA_W-1:0]         mar_out
);

  localparam int GPW = $clog2(NUM_GP);

  logic [DATA_W-1:0]   gp [NUM_GP];
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   mar;
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_result;

  always_comb begin
    bus = '0;
    if (BusDataSelect < 5'(NUM_GP)) begin
      bus = gp[BusDataSelect[GPW-1:0]];
    end else begin
      case (BusDataSelect)
        BUS_HI:  bus = hi;
        BUS_LO:  bus = lo;
        BUS_ZHI: bus = z[2*DATA_W-1:DATA_W];
        BUS_ZLO: bus = z[DATA_W-1:0];
        BUS_PC:  bus = pc;
        BUS_MDR: bus = mdr;
        default: bus = '0;
      endcase
    end
  end

  src_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (y),
    .b      (bus),
    .op     (ALU_op),
    .result (alu_result)
  );

  // All loads sample the same pre-edge bus, so any mix of enables is legal.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NUM_GP; i++) begin
        gp[i] <= '0;
      end
      pc  <= '0;
      ir  <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
      mdr <= '0;
      mar <= '0;
    end else begin
      if (e_GP)  gp[GP_addr] <= bus;
      if (e_IR)  ir  <= bus;
      if (e_Y)   y   <= bus;
      if (e_Z)   z   <= alu_result;
      if (e_HI)  hi  <= bus;
      if (e_LO)  lo  <= bus;
      if (e_MAR) mar <= bus;
      if (e_MDR) mdr <= MDR_read ? Mdatain : bus;
      if (e_PC) begin
        pc <= bus;
      end else if (incPC) begin
        pc <= pc + 1'b1;
      end
    end
  end

  assign bus_out = bus;
  assign pc_out  = pc;
  assign ir_out  = ir;
  assign mar_out = mar;

endmodule

// File: tb/tb_src_datapath.sv
// Directed self-checking bench for src_datapath with a behavioural register/ALU model.
// Expectations for MUL/DIV follow SRC_MULDIV_EN as the DUT is built.
module tb_src_datapath;

  localparam logic [8:0] M_PC  = 9'h001;
  localparam logic [8:0] M_IR  = 9'h002;
  localparam logic [8:0] M_Y   = 9'h004;
  localparam logic [8:0] M_Z   = 9'h008;
  localparam logic [8:0] M_HI  = 9'h010;
  localparam logic [8:0] M_LO  = 9'h020;
  localparam logic [8:0] M_MDR = 9'h040;
  localparam logic [8:0] M_MAR = 9'h080;
  localparam logic [8:0] M_GP  = 9'h100;

  logic        clock = 1'b0;
  logic        clear;
  logic        incPC;
  logic [3:0]  GP_addr;
  logic [31:0] Mdatain;
  logic        MDR_read;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic [31:0] bus_out, pc_out, ir_out, mar_out;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [31:0] m_gp [16];
  logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_mar;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  src_datapath dut (
    .clock(clock), .clear(clear), .incPC(incPC), .GP_addr(GP_addr),
    .Mdatain(Mdatain), .MDR_read(MDR_read),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
    .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .bus_out(bus_out), .pc_out(pc_out), .ir_out(ir_out), .mar_out(mar_out)
  );

  function automatic logic [31:0] model_bus(input logic [4:0] sel);
    if (sel < 5'd16) return m_gp[sel[3:0]];
    case (sel)
      5'd16:   return m_hi;
      5'd17:   return m_lo;
      5'd18:   return m_z[63:32];
      5'd19:   return m_z[31:0];
      5'd20:   return m_pc;
      5'd21:   return m_mdr;
      default: return 32'h0;
    endcase
  endfunction

  // Shifts and rotates are modelled one bit position at a time.
  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    int          n;
    logic [31:0] r;
    int          q, rm;
    n = int'(b[4:0]);
    r = a;
    case (op)
      4'd0:  return {32'h0, a + b};
      4'd1:  return {32'h0, a - b};
      4'd2:  return {32'h0, a & b};
      4'd3:  return {32'h0, a | b};
      4'd4:  begin for (int i = 0; i < n; i++) r = {1'b0, r[31:1]}; return {32'h0, r}; end
      4'd5:  begin for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; return {32'h0, r}; end
      4'd6:  begin for (int i = 0; i < n; i++) r = {r[30:0], 1'b0}; return {32'h0, r}; end
      4'd7:  begin for (int i = 0; i < n; i++) r = {r[0], r[31:1]}; return {32'h0, r}; end
      4'd8:  begin for (int i = 0; i < n; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
`ifdef SRC_MULDIV_EN
      4'd9:  return 64'(longint'(int'(a)) * longint'(int'(b)));
      4'd10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q  = int'(a) / int'(b);
        rm = int'(a) % int'(b);
        return {rm, q};
      end
`endif
      4'd11: return {32'h0, 32'h0 - b};
      4'd12: return {32'h0, ~b};
      4'd13: return {32'h0, b};
      4'd14: return {32'h0, b + 32'h1};
      default: return 64'h0;
    endcase
  endfunction

  always @(posedge clock) begin : model_update
    logic [31:0] b;
    logic [63:0] alu;
    b   = model_bus(BusDataSelect);
    alu = model_alu(m_y, b, ALU_op);
    if (!clear) begin
      for (int i = 0; i < 16; i++) m_gp[i] <= 32'h0;
      m_pc <= 32'h0; m_ir <= 32'h0; m_y <= 32'h0; m_z <= 64'h0;
      m_hi <= 32'h0; m_lo <= 32'h0; m_mdr <= 32'h0; m_mar <= 32'h0;
    end else begin
      if (e_GP)  m_gp[GP_addr] <= b;
      if (e_IR)  m_ir  <= b;
      if (e_Y)   m_y   <= b;
      if (e_Z)   m_z   <= alu;
      if (e_HI)  m_hi  <= b;
      if (e_LO)  m_lo  <= b;
      if (e_MAR) m_mar <= b;
      if (e_MDR) m_mdr <= MDR_read ? Mdatain : b;
      if (e_PC)       m_pc <= b;
      else if (incPC) m_pc <= m_pc + 32'h1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_bus", {32'h0, bus_out}, {32'h0, model_bus(BusDataSelect)});
      checkOutput("model_pc",  {32'h0, pc_out},  {32'h0, m_pc});
      checkOutput("model_ir",  {32'h0, ir_out},  {32'h0, m_ir});
      checkOutput("model_mar", {32'h0, mar_out}, {32'h0, m_mar});
    end
  end

  task automatic idle();
    {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP} = 9'h0;
    incPC = 1'b0; MDR_read = 1'b0; GP_addr = 4'd0; Mdatain = 32'h0;
    ALU_op = 4'd15; BusDataSelect = 5'd31; clear = 1'b1;
  endtask

  task automatic applyStimulus(input logic [4:0] sel, input logic [8:0] en,
                               input logic [3:0] op, input logic [3:0] gp,
                               input logic [31:0] mdat, input logic mrd, input logic inc);
    BusDataSelect = sel; ALU_op = op; GP_addr = gp;
    Mdatain = mdat; MDR_read = mrd; incPC = inc;
    {e_GP, e_MAR, e_MDR, e_LO, e_HI, e_Z, e_Y, e_IR, e_PC} = en;
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic loadMdr(input logic [31:0] v);
    applyStimulus(5'd31, M_MDR, 4'd15, 4'd0, v, 1'b1, 1'b0);
  endtask

  task automatic loadReg(input logic [31:0] v, input logic [8:0] en, input logic [3:0] gp);
    loadMdr(v);
    applyStimulus(5'd21, en, 4'd15, gp, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic aluOp(input logic [4:0] sel, input logic [3:0] op);
    applyStimulus(sel, M_Z, op, 4'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic readBus(input logic [4:0] sel, input string name, input logic [31:0] exp);
    BusDataSelect = sel;
    @(negedge clock);
    checkOutput(name, {32'h0, bus_out}, {32'h0, exp});
    BusDataSelect = 5'd31;
  endtask

  initial begin
    idle();
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    check_en = 1'b1;
    checkOutput("reset_pc",  {32'h0, pc_out},  64'h0);
    checkOutput("reset_ir",  {32'h0, ir_out},  64'h0);
    checkOutput("reset_mar", {32'h0, mar_out}, 64'h0);
    readBus(5'd21, "reset_mdr", 32'h0);

    // NOT via MDR -> R2 -> Z -> R5
    loadReg(32'h000000F0, M_GP, 4'd2);
    aluOp(5'd2, 4'd12);
    applyStimulus(5'd19, M_GP, 4'd15, 4'd5, 32'h0, 1'b0, 1'b0);
    readBus(5'd5, "not_r5", 32'hFFFFFF0F);

    // ADD/SUB wrap
    loadReg(32'h00000001, M_GP, 4'd1);
    loadReg(32'h7FFFFFFF, M_Y, 4'd0);
    aluOp(5'd1, 4'd0);
    readBus(5'd19, "add_zlo", 32'h80000000);
    readBus(5'd18, "add_zhi", 32'h0);
    loadReg(32'h0, M_Y, 4'd0);
    aluOp(5'd1, 4'd1);
    readBus(5'd19, "sub_zlo", 32'hFFFFFFFF);

    // Shifts and rotates by 1
    loadReg(32'h80000001, M_Y, 4'd0);
    aluOp(5'd1, 4'd5); readBus(5'd19, "shra", 32'hC0000000);
    aluOp(5'd1, 4'd7); readBus(5'd19, "ror",  32'hC0000000);
    aluOp(5'd1, 4'd8); readBus(5'd19, "rol",  32'h00000003);
    aluOp(5'd1, 4'd4); readBus(5'd19, "shr",  32'h40000000);
    aluOp(5'd1, 4'd6); readBus(5'd19, "shl",  32'h00000002);
    aluOp(5'd1, 4'd14); readBus(5'd19, "inc", 32'h00000002);
    aluOp(5'd1, 4'd11); readBus(5'd19, "neg", 32'hFFFFFFFF);

    // MUL/DIV (R0 is never written, so it supplies B=0)
    loadReg(32'h00000005, M_GP, 4'd3);
    loadReg(32'hFFFFFFFD, M_Y, 4'd0);
    aluOp(5'd3, 4'd9);
`ifdef SRC_MULDIV_EN
    readBus(5'd18, "mul_zhi", 32'hFFFFFFFF);
    readBus(5'd19, "mul_zlo", 32'hFFFFFFF1);
`else
    readBus(5'd18, "mul_zhi", 32'h0);
    readBus(5'd19, "mul_zlo", 32'h0);
`endif
    loadReg(32'h00000011, M_Y, 4'd0);
    aluOp(5'd3, 4'd10);
`ifdef SRC_MULDIV_EN
    readBus(5'd18, "div_zhi", 32'h00000002);
    readBus(5'd19, "div_zlo", 32'h00000003);
`else
    readBus(5'd18, "div_zhi", 32'h0);
    readBus(5'd19, "div_zlo", 32'h0);
`endif
    aluOp(5'd0, 4'd10);
`ifdef SRC_MULDIV_EN
    readBus(5'd18, "div0_zhi", 32'h00000011);
    readBus(5'd19, "div0_zlo", 32'hFFFFFFFF);
`else
    readBus(5'd18, "div0_zhi", 32'h0);
    readBus(5'd19, "div0_zlo", 32'h0);
`endif

    // PC wrap and load-over-increment priority
    loadReg(32'hFFFFFFFF, M_PC, 4'd0);
    applyStimulus(5'd31, 9'h0, 4'd15, 4'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("pc_wrap", {32'h0, pc_out}, 64'h0);
    loadReg(32'h00000010, M_GP, 4'd4);
    applyStimulus(5'd4, M_PC, 4'd15, 4'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("pc_load_wins", {32'h0, pc_out}, 64'h10);
    applyStimulus(5'd31, 9'h0, 4'd15, 4'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("pc_inc", {32'h0, pc_out}, 64'h11);

    // Simultaneous enables all see the pre-edge bus
    loadMdr(32'hA5A50001);
    applyStimulus(5'd21, M_IR | M_MAR | M_HI | M_LO | M_Y | M_MDR | M_GP,
                  4'd15, 4'd7, 32'h12345678, 1'b1, 1'b0);
    checkOutput("simul_ir",  {32'h0, ir_out},  64'hA5A50001);
    checkOutput("simul_mar", {32'h0, mar_out}, 64'hA5A50001);
    readBus(5'd16, "simul_hi",  32'hA5A50001);
    readBus(5'd17, "simul_lo",  32'hA5A50001);
    readBus(5'd7,  "simul_r7",  32'hA5A50001);
    readBus(5'd21, "simul_mdr", 32'h12345678);
    readBus(5'd25, "bus_unused_code", 32'h0);
    aluOp(5'd7, 4'd13);
    readBus(5'd19, "pass_from_y_sample", 32'hA5A50001);

    // Clear overrides every enable mid-sequence
    BusDataSelect = 5'd21; ALU_op = 4'd13; incPC = 1'b1;
    {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP} = 9'h1FF;
    MDR_read = 1'b1; Mdatain = 32'hDEADBEEF; GP_addr = 4'd9;
    clear = 1'b0;
    @(posedge clock);
    #1;
    idle();
    checkOutput("clear_pc",  {32'h0, pc_out},  64'h0);
    checkOutput("clear_ir",  {32'h0, ir_out},  64'h0);
    checkOutput("clear_mar", {32'h0, mar_out}, 64'h0);
    for (int s = 0; s < 22; s++) begin
      readBus(5'(s), "clear_bus", 32'h0);
    end

    @(negedge clock);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/src_datapath.md
SRC_DATAPATH -- requirements
Module: src_datapath

Interface
REQ-001 Parameter NUM_GP, 16, number of general-purpose registers R0..R15; GP_addr width is 4 bits.
REQ-002 Parameter DATA_W, 32, data width of the bus and all architectural registers.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 clear  in  1  reset; synchronous, active-low.
REQ-005 incPC  in  1  PC increment request.
REQ-006 GP_addr  in  4  selects the GP register written when e_GP=1.
REQ-007 Mdatain  in  32  memory read data.
REQ-008 MDR_read  in  1  MDR input source select: 1 = Mdatain, 0 = bus.
REQ-009 e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  in  1 each  register load enables.
REQ-010 ALU_op  in  4  ALU operation select.
REQ-011 BusDataSelect  in  5  bus source select.
REQ-012 bus_out  out  32  current bus value.
REQ-013 pc_out, ir_out, mar_out  out  32 each  current register values.

Function
REQ-014 The bus SHALL be a combinational mux on BusDataSelect:
- 0..15: R0..R15
- 16: HI
- 17: LO
- 18: Z[63:32]
- 19: Z[31:0]
- 20: PC
- 21: MDR
- all other codes: 0
REQ-015 Each enabled register (IR, Y, HI, LO, MAR, PC, and R[GP_addr] when e_GP=1) SHALL load the bus value on the rising edge; with its enable low it SHALL hold.
REQ-016 PC SHALL load the bus when e_PC=1; otherwise, when incPC=1, it SHALL increment by 1 modulo 2^32; a bus load SHALL win when both are asserted.
REQ-017 MDR SHALL load (MDR_read ? Mdatain : bus) when e_MDR=1.
REQ-018 ALU operands SHALL be A = Y and B = bus; the 64-bit ALU result SHALL load into Z when e_Z=1.
REQ-019 ALU_op encoding, with all results written to Z[31:0] and Z[63:32]=0 unless stated:
- 0 ADD, 1 SUB (A-B), 2 AND, 3 OR
- 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 ROL; shift/rotate amount = B[4:0]
- 9 MUL: signed 64-bit product into Z
- 10 DIV: signed; Z[31:0]=quotient, Z[63:32]=remainder
- 11 NEG: -B
- 12 NOT: ~B
- 13 PASS: B
- 14 INC: B+1
- 15: result 0
REQ-020 ADD, SUB, NEG and INC SHALL wrap modulo 2^32; no flags are produced.
REQ-021 DIV with B=0 SHALL give quotient 0xFFFFFFFF and remainder A.
REQ-022 Simultaneous enables SHALL all take effect on the same edge, each sampling the pre-edge bus value.
REQ-023 Combinational paths SHALL be bus mux and ALU only, with no latch inference; bus-to-register latency is 1 cycle.

Reset
REQ-024 While clear=0 at a rising edge, every register (R0..R15, PC, IR, Y, Z, HI, LO, MDR, MAR) SHALL become 0, overriding all enables.
REQ-025 A clear asserted mid-sequence SHALL discard the in-flight operation; bus_out then reflects zeroed registers.

Configuration
REQ-026 With macro SRC_MULDIV_EN defined, MUL and DIV SHALL behave per REQ-019 and REQ-021.
REQ-027 Without SRC_MULDIV_EN, ALU_op 9 and 10 SHALL produce Z=0 and no multiplier or divider SHALL be synthesized.

Structure
REQ-028 A shared package SHALL hold the ALU_op and BusDataSelect encodings as named constants, plus the DATA_W default.
REQ-029 The ALU SHALL be a separate sub-module src_alu (A, B, op in; 64-bit result out); the registers and bus mux stay in src_datapath.

Verification
REQ-030 NOT: load Mdatain=0x000000F0 via MDR into R2, select R2 with ALU_op=12 and e_Z=1, then move Z[31:0] into R5 -> R5=0xFFFFFF0F.
REQ-031 ADD/SUB: Y=0x7FFFFFFF, B=1 -> ADD gives Z[31:0]=0x80000000; Y=0, B=1 -> SUB gives 0xFFFFFFFF.
REQ-032 MUL/DIV (macro on): Y=-3, B=5 -> MUL gives Z=0xFFFFFFFF_FFFFFFF1; Y=17, B=5 -> DIV gives Z=0x00000002_00000003; B=0 -> Z=0x00000011_FFFFFFFF.
REQ-033 Shifts: Y=0x80000001, B=1 -> SHRA gives 0xC0000000, ROR gives 0xC0000000, ROL gives 0x00000003.
REQ-034 PC: PC=0xFFFFFFFF with incPC=1 -> 0; e_PC=1 and incPC=1 with bus=0x10 -> PC=0x10.
REQ-035 Reset: load all registers with nonzero values, pull clear=0 for one edge -> every register and pc_out, ir_out, mar_out read 0.
